fpu_pack: RTL



---
 rtl/fpu_pack.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fpu_pack.sv
// IEEE-754 result packer: normalizes an unpacked sign/exponent/mantissa one bit per cycle,
// rounds to nearest-even and emits a packed word behind valid/ready handshakes.
module fpu_pack #(
  parameter int unsigned bitness    = 64,
  parameter int unsigned exp_width  = 11,
  parameter int unsigned frac_width = 52
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sign,
  input  logic signed [exp_width+1:0] in_exp,
  input  logic [frac_width+3:0]       in_mant,
  input  logic                        in_nan,
  input  logic                        in_inf,
  input  logic                        in_zero,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [bitness-1:0]          result,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        inexact
);

  localparam int unsigned M  = frac_width + 4;
  localparam int unsigned EW = exp_width + 2;
  localparam int CollapseLim = -(int'(frac_width) + 2);
  localparam int MaxExpInt   = (1 << exp_width) - 1;

  localparam logic signed [EW-1:0] ExpOne      = EW'(1);
  localparam logic signed [EW-1:0] ExpCollapse = EW'(CollapseLim);
  localparam logic signed [EW-1:0] ExpMax      = EW'(MaxExpInt);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [M-1:0]          mant_q, mant_d;
  logic [bitness-1:0]    result_q, result_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  inx_q, inx_d;

  logic                  round_up;
  logic                  rnd_inexact;
  logic [M-1:0]          rnd_sum;
  logic [M-1:0]          rnd_mant;
  logic signed [EW-1:0]  rnd_exp;
  logic [exp_width-1:0]  exp_field;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    round_up    = 1'b0;
    rnd_inexact = 1'b0;
    rnd_sum     = mant_q;
    rnd_mant    = mant_q;
    rnd_exp     = exp_q;
    exp_field   = '0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = in_exp;
          mant_d = in_mant;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          inx_d  = 1'b0;
          if (in_nan) begin
            result_d = {1'b0, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};
            state_d  = StDone;
          end else if (in_inf) begin
            result_d = {in_sign, {exp_width{1'b1}}, {frac_width{1'b0}}};
            state_d  = StDone;
          end else if (in_zero || (in_mant == '0)) begin
            result_d = {in_sign, {(bitness-1){1'b0}}};
            state_d  = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end

      StNorm: begin
        if (mant_q[M-1]) begin
          mant_d = {1'b0, mant_q[M-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + ExpOne;
        end else if (exp_q < ExpCollapse) begin
          // Too far below the subnormal range: only the sticky information survives.
          mant_d = {{(M-1){1'b0}}, |mant_q};
          exp_d  = ExpOne;
        end else if (exp_q < ExpOne) begin
          mant_d = {1'b0, mant_q[M-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + ExpOne;
        end else if (!mant_q[M-2] && (exp_q > ExpOne)) begin
          mant_d = {mant_q[M-2:0], 1'b0};
          exp_d  = exp_q - ExpOne;
        end else begin
          state_d = StRound;
        end
      end

      StRound: begin
        round_up    = mant_q[1] & (mant_q[0] | mant_q[2]);
        rnd_inexact = mant_q[1] | mant_q[0];
        rnd_sum     = mant_q + {{(M-3){1'b0}}, round_up, 2'b00};
        if (rnd_sum[M-1]) begin
          rnd_mant = {1'b0, rnd_sum[M-1:2], rnd_sum[1] | rnd_sum[0]};
          rnd_exp  = exp_q + ExpOne;
        end else begin
          rnd_mant = rnd_sum;
          rnd_exp  = exp_q;
        end
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        exp_field = rnd_mant[M-2] ? rnd_exp[exp_width-1:0] : '0;
        unf_d     = rnd_inexact & ~mant_q[M-2];
        if (rnd_exp >= ExpMax) begin
          result_d = {sign_q, {exp_width{1'b1}}, {frac_width{1'b0}}};
          ovf_d    = 1'b1;
          inx_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_field, rnd_mant[M-3:2]};
          ovf_d    = 1'b0;
          inx_d    = rnd_inexact;
        end
        mant_d  = rnd_mant;
        exp_d   = rnd_exp;
        state_d = StDone;
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule
